ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, instantiated in the EX stage.
//  Sits directly upstream of ctrl: drives stallreq_ex_i there to freeze the pipeline while a
//  division is in flight, then hands a registered result back to the EX stage. One quotient bit per cycle.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  5   iteration counter width; must equal clog2(XLEN)
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     reset; synchronous, active-high
//  start_i         in   1     EX holds a divide op; sampled only in IDLE
//  op_i            in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend_i      in   XLEN  rs1 value; sampled with start_i
//  divisor_i       in   XLEN  rs2 value; sampled with start_i
//  annul_i         in   1     flush; cancels any divide in progress
//  hold_i          in   1     EX is held by ctrl for another reason; result must be kept
//  stallreq_o      out  1     to ctrl stallreq_ex_i; EX must not advance
//  result_o        out  XLEN  quotient or remainder, valid when result_valid_o=1
//  result_valid_o  out  1     result_o is final this cycle
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, partial remainder/quotient=0, result_o=0, result_valid_o=0, stallreq_o=0.
//  FSM states: IDLE, CALC, DONE.
//  - IDLE: start_i=1 & annul_i=0 -> latch |dividend| and |divisor|; for signed ops these are
//    two's-complement magnitudes. Also latch the quotient sign (sign_a^sign_b) and the remainder
//    sign (sign_a), counter=XLEN-1.
//    - divisor==0 -> DONE directly, result = all-ones for DIV/DIVU, dividend for REM/REMU.
//    - otherwise -> CALC.
//  - CALC: one restoring step per cycle.
//    - rem' = {rem[XLEN-2:0], quo[XLEN-1]}; subtract divisor; if no borrow keep the difference and shift in quotient 1, else keep rem' and shift in 0.
//    - counter decrements; at counter==0 the step completes -> DONE.
//  - DONE: result_o = sign-corrected quotient (op_i[1]=0) or remainder (op_i[1]=1).
//    - result_valid_o=1, stallreq_o=0.
//    - hold_i=1 -> stay in DONE; else -> IDLE.
//  stallreq_o (combinational) = ~rst & ~annul_i & ((IDLE & start_i) | CALC).
//    Stall rises in the same cycle start_i is first seen, so ctrl freezes EX with no bubble.
//  Latency, start to result_valid:
//    - normal op: 1 IDLE cycle + XLEN CALC cycles; stall for 33 cycles, result in cycle 34.
//    - divide by zero: stall for 1 cycle, result in cycle 2.
//  Sign rules:
//    - quotient negated iff signed op & quotient sign=1 & divisor!=0.
//    - remainder negated iff signed op & dividend negative.
//    - overflow 0x80000000 / 0xFFFFFFFF (DIV) gives 0x80000000, REM gives 0 with no special-case
//      logic, because magnitude 2^31 is representable unsigned.
//  Op/sign latched at start; op_i is ignored after IDLE.
//  Back-to-back divides:
//    - DONE->IDLE coincides with EX advancing, so a following divide's start_i is seen in IDLE on the next cycle.
//    - No start_i is accepted in DONE.
//  annul_i: from any state -> IDLE next edge; result_valid_o and stallreq_o forced 0 the same cycle;
//    datapath registers need not clear.
//  rst mid-operation: IDLE with all reset values on the next edge; no partial result is ever flagged valid.
// STRUCTURE
//  Op encodings are `define constants in the shared buceros header, alongside the ALU ops:
//    `DIV_OP_DIV/DIVU/REM/REMU and `DIV_ST_IDLE/CALC/DONE.
//  One combinational sub-module, div_step: takes rem, quo_msb, divisor and returns next rem and quotient bit.
//  FSM, counter, sign logic and output muxing stay in ex_div.
// TESTING
//  1. DIVU 100/7 -> stallreq_o high exactly 33 cycles, then result_o=14, valid for 1 cycle.
//     Repeat as REMU -> result_o=2.
//  2. DIV 0xFFFFFFF9(-7) / 2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1);
//     DIV 7 / 0xFFFFFFFE(-2) -> 0xFFFFFFFD; REM -> 1.
//  3. Divide by zero:
//     - DIVU 5/0 -> 0xFFFFFFFF, with stallreq_o for 1 cycle only.
//     - REM 0xFFFFFFFB/0 -> 0xFFFFFFFB.
//     - DIV 5/0 -> 0xFFFFFFFF.
//  4. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. Cancellation:
//     - annul_i pulsed at CALC cycle 10 -> stallreq_o low that cycle, IDLE next, result_valid_o never asserts.
//     - rst pulsed mid-CALC -> same outcome.
//  6. Hold and back-to-back:
//     - hold_i=1 for 3 cycles in DONE -> result_o stable and valid for 4 cycles.
//     - Then two back-to-back DIVU (20/3, 9/4) -> results 6 and 2, each preceded by a 33-cycle stall.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared constants, op/state encodings and helpers for the EX-stage divider.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ex_div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;   // must equal clog2(XLEN)

  // Bit 1 selects remainder, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'b00,
    DIV_ST_CALC = 2'b01,
    DIV_ST_DONE = 2'b10
  } div_state_e;

  // Two's-complement magnitude when neg is set, value unchanged otherwise.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// ex_div_if: EX-stage <-> divider request/result bundle.
// Latency: n/a (wires only).
// Backpressure: stallreq tells ctrl to freeze EX; hold keeps a finished result alive.
// Ports: start/op/dividend/divisor/annul/hold from EX; stallreq/result/result_valid back.
interface ex_div_if;
  import ex_div_pkg::*;

  logic            start;
  div_op_e         op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            annul;
  logic            hold;
  logic            stallreq;
  logic [XLEN-1:0] result;
  logic            result_valid;

  // EX stage side
  modport master (
    output start, op, dividend, divisor, annul, hold,
    input  stallreq, result, result_valid
  );

  // Divider side
  modport slave (
    input  start, op, dividend, divisor, annul, hold,
    output stallreq, result, result_valid
  );

endinterface

// File: rtl/ex_div_step.sv
// ex_div_step: one restoring-division step (shift in dividend bit, trial subtract).
// Latency: combinational.
// Backpressure: none.
// Ports: rem/quo_msb/divisor in; rem_next/q_bit out.
module ex_div_step
  import ex_div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            quo_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  // The shifted partial remainder needs one extra bit: with an unsigned divisor
  // >= 2^(XLEN-1) the remainder's msb can be set before the shift.
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  always_comb begin
    shifted  = {rem, quo_msb};
    q_bit    = (shifted >= {1'b0, divisor});
    // When the subtract succeeds the true difference is below the divisor,
    // so the modular XLEN-bit difference is exact.
    diff     = shifted[XLEN-1:0] - divisor;
    rem_next = q_bit ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU in the EX stage.
// Latency: start to result_valid = 1 + XLEN cycles (2 cycles for divide by zero).
// Backpressure: stallreq freezes EX while busy; hold keeps the result valid in DONE.
// Ports: clk, rst (sync, active-high), bus (ex_div_if.slave).
module ex_div
  import ex_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvsr_q;
  logic             is_rem_q;
  logic             qneg_q;
  logic             rneg_q;

  // Operand preparation, only meaningful while IDLE sees start.
  logic            op_signed;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;

  always_comb begin
    op_signed = ~bus.op[0];
    sign_a    = op_signed & bus.dividend[XLEN-1];
    sign_b    = op_signed & bus.divisor[XLEN-1];
    mag_a     = cond_neg(bus.dividend, sign_a);
    mag_b     = cond_neg(bus.divisor, sign_b);
    div_zero  = (bus.divisor == '0);
  end

  logic            accept;
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  assign accept = (state_q == DIV_ST_IDLE) & bus.start & ~bus.annul;

  ex_div_step u_step (
    .rem      (rem_q),
    .quo_msb  (quo_q[XLEN-1]),
    .divisor  (dvsr_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_ST_IDLE: if (accept) state_d = div_zero ? DIV_ST_DONE : DIV_ST_CALC;
      DIV_ST_CALC: if (cnt_q == '0) state_d = DIV_ST_DONE;
      DIV_ST_DONE: if (!bus.hold) state_d = DIV_ST_IDLE;
      default:     state_d = DIV_ST_IDLE;
    endcase
    if (bus.annul) state_d = DIV_ST_IDLE;
  end

  // Datapath. Annul only redirects the FSM; stale datapath contents are
  // never visible because result_valid depends on DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      case (state_q)
        DIV_ST_IDLE: begin
          if (accept) begin
            cnt_q    <= CNT_W'(XLEN - 1);
            dvsr_q   <= mag_b;
            is_rem_q <= bus.op[1];
            // Divide by zero never negates the all-ones quotient.
            qneg_q   <= (sign_a ^ sign_b) & ~div_zero;
            rneg_q   <= sign_a;
            if (div_zero) begin
              // Remainder path re-applies the dividend sign, giving back the dividend.
              quo_q <= '1;
              rem_q <= mag_a;
            end else begin
              quo_q <= mag_a;
              rem_q <= '0;
            end
          end
        end
        DIV_ST_CALC: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.stallreq     = ~rst & ~bus.annul &
                       (((state_q == DIV_ST_IDLE) & bus.start) | (state_q == DIV_ST_CALC));
    bus.result_valid = ~rst & ~bus.annul & (state_q == DIV_ST_DONE);
    bus.result       = '0;
    if (bus.result_valid)
      bus.result = is_rem_q ? cond_neg(rem_q, rneg_q) : cond_neg(quo_q, qneg_q);
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div.
// Latency: n/a.
// Backpressure: exercises hold and back-to-back starts.
module tb_ex_div;
  import ex_div_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_div_if dif ();

  ex_div u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a divide at the current time (low clock phase), counts stall cycles,
  // checks the result, optionally holds it, and returns in IDLE at a low phase.
  task automatic run_div(input string tag, input div_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int exp_stall, input int hold_cyc);
    int stall;
    dif.start    = 1'b1;
    dif.op       = op;
    dif.dividend = a;
    dif.divisor  = b;
    #1;
    stall = 0;
    while (dif.stallreq && stall < 100) begin
      stall++;
      @(negedge clk);
      dif.start = 1'b0;
      #1;
    end
    dif.start = 1'b0;
    check({tag, " stall"}, stall, exp_stall);
    check({tag, " valid"}, {31'd0, dif.result_valid}, 32'd1);
    check({tag, " result"}, dif.result, exp);
    if (hold_cyc > 0) dif.hold = 1'b1;
    for (int k = 0; k < hold_cyc; k++) begin
      @(negedge clk);
      #1;
      check({tag, " held valid"}, {31'd0, dif.result_valid}, 32'd1);
      check({tag, " held result"}, dif.result, exp);
    end
    dif.hold = 1'b0;
    @(negedge clk);
    #1;
    check({tag, " valid drops"}, {31'd0, dif.result_valid}, 32'd0);
  endtask

  // DIVU 100/7 cancelled at CALC cycle 10 by annul or by rst.
  task automatic cancel_test(input string tag, input bit use_rst);
    int nv;
    dif.start    = 1'b1;
    dif.op       = DIV_OP_DIVU;
    dif.dividend = 32'd100;
    dif.divisor  = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check({tag, " busy before cancel"}, {31'd0, dif.stallreq}, 32'd1);
    if (use_rst) rst = 1'b1;
    else         dif.annul = 1'b1;
    #1;
    check({tag, " stall same cycle"}, {31'd0, dif.stallreq}, 32'd0);
    check({tag, " valid same cycle"}, {31'd0, dif.result_valid}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    dif.annul = 1'b0;
    #1;
    check({tag, " idle stall"}, {31'd0, dif.stallreq}, 32'd0);
    check({tag, " idle result"}, dif.result, 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (dif.result_valid) nv++;
    end
    check({tag, " never valid"}, nv, 0);
  endtask

  initial begin
    dif.start    = 1'b1;
    dif.op       = DIV_OP_DIVU;
    dif.dividend = 32'd0;
    dif.divisor  = 32'd0;
    dif.annul    = 1'b0;
    dif.hold     = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("stall masked in reset", {31'd0, dif.stallreq}, 32'd0);
    dif.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    #1;
    check("reset stallreq", {31'd0, dif.stallreq}, 32'd0);
    check("reset valid", {31'd0, dif.result_valid}, 32'd0);
    check("reset result", dif.result, 32'd0);

    run_div("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_div("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_div("div -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_div("rem -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_div("div 7/-2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_div("rem 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_div("divu 5/0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("rem -5/0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 0);
    run_div("div 5/0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_div("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_div("divu big", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 0);
    run_div("remu big", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0);

    cancel_test("annul", 1'b0);
    cancel_test("rst", 1'b1);

    run_div("hold divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 3);
    run_div("b2b divu 20/3", DIV_OP_DIVU, 32'd20, 32'd3, 32'd6, 33, 0);
    run_div("b2b divu 9/4", DIV_OP_DIVU, 32'd9, 32'd4, 32'd2, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
